baud_tick_gen: RTL and testbench

BAUD_TICK_GEN -- requirements
Module: baud_tick_gen

---
 rtl/baud_tick_gen.sv | 193 +++++++++++++++++++
 tb/tb_baud_tick_gen.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/baud_tick_gen.sv
// ---------------------------------------------------------------------------
// baud_tick_gen
//
// Purpose:
//    UART timing generator. A prescaler divides the system clock down to
//    BAUD*OVERSAMPLE (rx_tick), a bit-phase counter further divides that by
//    OVERSAMPLE (tx_tick), and a registered square wave at BAUD (baud_clk)
//    is produced for older BaudGen users.
//
// Parameters:
//    CLK_HZ      system clock frequency in Hz
//    OVERSAMPLE  rx ticks per bit (even, at least 4)
//    DIV_W       prescaler counter width
//
// Ports:
//    clk        in   system clock, rising edge
//    resetn     in   asynchronous active-low reset
//    enable     in   high runs the generator, low holds it idle and cleared
//    baud_rate  in   rate select: 0=9600, 1=19200, 2=57600, 3=115200
//    sync       in   one-cycle pulse that restarts bit timing
//    rx_tick    out  one-cycle pulse at BAUD*OVERSAMPLE
//    tx_tick    out  one-cycle pulse at BAUD, coincident with the last rx_tick
//    baud_clk   out  50% duty square wave at BAUD
//
// Configuration macro:
//    BAUD_FRAC_EN  when defined, a 4-bit fractional accumulator stretches
//                  selected prescaler periods to DIV+1 so the average rate
//                  tracks CLK_HZ/(BAUD*OVERSAMPLE) more closely. When
//                  undefined the period is always the integer divisor.
// ---------------------------------------------------------------------------
module baud_tick_gen #(
    parameter int unsigned CLK_HZ     = 7_372_800,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_W      = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enable,
    input  logic [1:0] baud_rate,
    input  logic       sync,
    output logic       rx_tick,
    output logic       tx_tick,
    output logic       baud_clk
);

    localparam longint unsigned CLK_L = 64'(CLK_HZ);
    localparam longint unsigned OS_L  = 64'(OVERSAMPLE);

    localparam longint unsigned DIV0 = CLK_L / (64'd9600   * OS_L);
    localparam longint unsigned DIV1 = CLK_L / (64'd19200  * OS_L);
    localparam longint unsigned DIV2 = CLK_L / (64'd57600  * OS_L);
    localparam longint unsigned DIV3 = CLK_L / (64'd115200 * OS_L);
    localparam longint unsigned DIV_LIMIT = 64'd1 << DIV_W;

    localparam int unsigned OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    // Refuse to build configurations that cannot produce a sane tick stream.
    if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_badOversample
        $error("baud_tick_gen: OVERSAMPLE must be even and at least 4");
    end
    if (DIV0 < 2 || DIV1 < 2 || DIV2 < 2 || DIV3 < 2 ||
        DIV0 >= DIV_LIMIT || DIV1 >= DIV_LIMIT ||
        DIV2 >= DIV_LIMIT || DIV3 >= DIV_LIMIT) begin : g_badDivisor
        $error("baud_tick_gen: a divisor is below 2 or does not fit in DIV_W bits");
    end

    logic [DIV_W-1:0] preCnt_q, preCnt_d;
    logic [OS_W-1:0]  osCnt_q, osCnt_d;
    logic             rxTick_q, rxTick_d;
    logic             txTick_q, txTick_d;
    logic             baudClk_q, baudClk_d;
    logic [1:0]       rate_q;
    logic             rateLoaded_q;
    logic [DIV_W-1:0] divM1;
    logic             termCnt;
    logic             rateChange;
    logic             restart;

    always_comb begin
        divM1 = DIV_W'(DIV3 - 64'd1);
        case (rate_q)
            2'd0:    divM1 = DIV_W'(DIV0 - 64'd1);
            2'd1:    divM1 = DIV_W'(DIV1 - 64'd1);
            2'd2:    divM1 = DIV_W'(DIV2 - 64'd1);
            default: divM1 = DIV_W'(DIV3 - 64'd1);
        endcase
    end

`ifdef BAUD_FRAC_EN
    localparam longint unsigned FRAC0 = ((64'd16 * CLK_L) / (64'd9600   * OS_L)) % 64'd16;
    localparam longint unsigned FRAC1 = ((64'd16 * CLK_L) / (64'd19200  * OS_L)) % 64'd16;
    localparam longint unsigned FRAC2 = ((64'd16 * CLK_L) / (64'd57600  * OS_L)) % 64'd16;
    localparam longint unsigned FRAC3 = ((64'd16 * CLK_L) / (64'd115200 * OS_L)) % 64'd16;

    logic [3:0]   fracStep;
    logic [3:0]   fracAcc_q, fracAcc_d;
    logic         extra_q, extra_d;
    logic [DIV_W:0] termVal;

    always_comb begin
        fracStep = 4'(FRAC3);
        case (rate_q)
            2'd0:    fracStep = 4'(FRAC0);
            2'd1:    fracStep = 4'(FRAC1);
            2'd2:    fracStep = 4'(FRAC2);
            default: fracStep = 4'(FRAC3);
        endcase
    end

    // extra_q holds the carry from the previous wrap and lengthens the
    // current prescaler period by one cycle. The terminal value never
    // exceeds DIV, which always fits in DIV_W bits.
    assign termVal = {1'b0, divM1} + {{DIV_W{1'b0}}, extra_q};
    assign termCnt = ({1'b0, preCnt_q} == termVal);
`else
    assign termCnt = (preCnt_q == divM1);
`endif

    // The first edge after reset only loads the rate register; it is not a
    // user rate change, so it must not cost a restart cycle.
    assign rateChange = rateLoaded_q && (baud_rate != rate_q);
    assign restart    = !enable || sync || rateChange;

    always_comb begin
        preCnt_d = preCnt_q + DIV_W'(1);
        osCnt_d  = osCnt_q;
        rxTick_d = 1'b0;
        txTick_d = 1'b0;
`ifdef BAUD_FRAC_EN
        fracAcc_d = fracAcc_q;
        extra_d   = extra_q;
`endif
        if (restart) begin
            preCnt_d = '0;
            osCnt_d  = '0;
`ifdef BAUD_FRAC_EN
            fracAcc_d = '0;
            extra_d   = 1'b0;
`endif
        end else if (termCnt) begin
            preCnt_d = '0;
            rxTick_d = 1'b1;
            if (osCnt_q == OS_W'(OVERSAMPLE - 1)) begin
                osCnt_d  = '0;
                txTick_d = 1'b1;
            end else begin
                osCnt_d = osCnt_q + OS_W'(1);
            end
`ifdef BAUD_FRAC_EN
            {extra_d, fracAcc_d} = {1'b0, fracAcc_q} + {1'b0, fracStep};
`endif
        end
        // Derived from the next bit phase so baud_clk moves in step with os_cnt.
        baudClk_d = (osCnt_d >= OS_W'(OVERSAMPLE / 2));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            preCnt_q     <= '0;
            osCnt_q      <= '0;
            rxTick_q     <= 1'b0;
            txTick_q     <= 1'b0;
            baudClk_q    <= 1'b0;
            rate_q       <= 2'd0;
            rateLoaded_q <= 1'b0;
        end else begin
            preCnt_q     <= preCnt_d;
            osCnt_q      <= osCnt_d;
            rxTick_q     <= rxTick_d;
            txTick_q     <= txTick_d;
            baudClk_q    <= baudClk_d;
            rate_q       <= baud_rate;
            rateLoaded_q <= 1'b1;
        end
    end

`ifdef BAUD_FRAC_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fracAcc_q <= '0;
            extra_q   <= 1'b0;
        end else begin
            fracAcc_q <= fracAcc_d;
            extra_q   <= extra_d;
        end
    end
`endif

    assign rx_tick  = rxTick_q;
    assign tx_tick  = txTick_q;
    assign baud_clk = baudClk_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// ---------------------------------------------------------------------------
// tb_baud_tick_gen
//
// Drives two generators from one stimulus stream: one at the default clock
// (all divisors exact) and one at 8 MHz (fractional divisors). A reference
// model predicts every output each cycle from closed-form tick times measured
// since the last restart (enable low, sync, rate change or reset).
// ---------------------------------------------------------------------------
module tb_baud_tick_gen;

    localparam int OS   = 16;
    localparam int CLK0 = 7_372_800;
    localparam int CLK1 = 8_000_000;

    logic       clk;
    logic       resetn;
    logic       enable;
    logic       sync;
    logic [1:0] baud_rate;
    logic       rx0, tx0, bc0;
    logic       rx1, tx1, bc1;

    int compared;
    int mismatched;

    int   n[2];
    int   k[2];
    int   rateM[2];
    logic expRx[2];
    logic expTx[2];
    logic expBc[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    baud_tick_gen dut0 (
        .clk(clk), .resetn(resetn), .enable(enable), .baud_rate(baud_rate),
        .sync(sync), .rx_tick(rx0), .tx_tick(tx0), .baud_clk(bc0)
    );

    baud_tick_gen #(.CLK_HZ(CLK1)) dut1 (
        .clk(clk), .resetn(resetn), .enable(enable), .baud_rate(baud_rate),
        .sync(sync), .rx_tick(rx1), .tx_tick(tx1), .baud_clk(bc1)
    );

    function automatic int baudOf(input int r);
        case (r)
            0:       return 9600;
            1:       return 19200;
            2:       return 57600;
            default: return 115200;
        endcase
    endfunction

    function automatic int divOf(input int hz, input int r);
        return hz / (baudOf(r) * OS);
    endfunction

    function automatic int fracOf(input int hz, input int r);
`ifdef BAUD_FRAC_EN
        longint num;
        num = 64'(hz) * 16;
        return int'((num / longint'(baudOf(r) * OS)) % 16);
`else
        return 0;
`endif
    endfunction

    // Cycle (counted from the restart) at which the k-th rx tick appears:
    // k whole periods plus one extra cycle per fractional carry so far.
    function automatic int tickTime(input int hz, input int r, input int kk);
        return kk * divOf(hz, r) + ((kk - 1) * fracOf(hz, r)) / 16;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelEdge();
        for (int i = 0; i < 2; i++) begin
            int   hz;
            logic restartNow;
            hz = (i == 0) ? CLK0 : CLK1;
            if (!resetn) begin
                n[i] = 0; k[i] = 1; rateM[i] = -1;
                expRx[i] = 1'b0; expTx[i] = 1'b0; expBc[i] = 1'b0;
            end else begin
                restartNow = !enable || sync || (rateM[i] >= 0 && rateM[i] != int'(baud_rate));
                rateM[i] = int'(baud_rate);
                expRx[i] = 1'b0;
                expTx[i] = 1'b0;
                if (restartNow) begin
                    n[i] = 0;
                    k[i] = 1;
                end else begin
                    n[i]++;
                    if (n[i] == tickTime(hz, rateM[i], k[i])) begin
                        expRx[i] = 1'b1;
                        expTx[i] = ((k[i] % OS) == 0);
                        k[i]++;
                    end
                end
                expBc[i] = ((k[i] - 1) % OS) >= (OS / 2);
            end
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkOutput("rx0", rx0, expRx[0]);
        checkOutput("tx0", tx0, expTx[0]);
        checkOutput("bc0", bc0, expBc[0]);
        checkOutput("rx1", rx1, expRx[1]);
        checkOutput("tx1", tx1, expTx[1]);
        checkOutput("bc1", bc1, expBc[1]);
    endtask

    task automatic applyStimulus(input logic en, input logic [1:0] rate,
                                 input logic syn, input int cycles);
        enable    = en;
        baud_rate = rate;
        sync      = syn;
        stepCycle();
        sync = 1'b0;
        for (int c = 1; c < cycles; c++) stepCycle();
    endtask

    // Steps until the selected output pulses (0=rx0, 1=tx0, 2=rx1).
    task automatic waitEvent(input int which, input int limit, output int cnt);
        logic seen;
        seen = 1'b0;
        cnt  = 0;
        while (!seen && cnt < limit) begin
            stepCycle();
            cnt++;
            case (which)
                0:       seen = rx0;
                1:       seen = tx0;
                default: seen = rx1;
            endcase
        end
        if (!seen) checkOutput("eventTimeout", 0, 1);
    endtask

    initial begin
        int cnt;
        int highs;
        int rxSeen;
        int total;
        int steps;

        compared   = 0;
        mismatched = 0;
        resetn     = 1'b0;
        enable     = 1'b0;
        sync       = 1'b0;
        baud_rate  = 2'd0;

        $display("[TB] reset state");
        applyStimulus(1'b0, 2'd0, 1'b0, 3);
        checkOutput("resetRx", rx0, 0);
        checkOutput("resetTx", tx0, 0);
        checkOutput("resetBc", bc0, 0);

        $display("[TB] 115200 free run");
        baud_rate = 2'd3;
        enable    = 1'b1;
        resetn    = 1'b1;
        waitEvent(0, 100, cnt);
        checkOutput("firstRx", cnt, 4);
        waitEvent(0, 100, cnt);
        checkOutput("rxPeriod3", cnt, 4);
        waitEvent(1, 200, cnt);
        waitEvent(1, 200, cnt);
        checkOutput("txPeriod3", cnt, 64);
        highs = 0;
        for (int c = 0; c < 64; c++) begin
            stepCycle();
            highs += int'(bc0);
        end
        checkOutput("baudHigh", highs, 32);

        $display("[TB] reset mid-bit");
        applyStimulus(1'b1, 2'd3, 1'b0, 7);
        resetn = 1'b0;
        for (int c = 0; c < 5; c++) begin
            stepCycle();
            checkOutput("inResetRx", rx0, 0);
            checkOutput("inResetBc", bc0, 0);
        end
        resetn = 1'b1;
        waitEvent(0, 100, cnt);
        checkOutput("rstRx", cnt, 4);

        $display("[TB] 9600 then switch to 57600");
        applyStimulus(1'b1, 2'd0, 1'b0, 1);
        waitEvent(0, 200, cnt);
        checkOutput("rxPeriod0a", cnt, 48);
        waitEvent(0, 200, cnt);
        checkOutput("rxPeriod0b", cnt, 48);
        waitEvent(1, 2000, cnt);
        waitEvent(1, 2000, cnt);
        checkOutput("txPeriod0", cnt, 768);
        applyStimulus(1'b1, 2'd0, 1'b0, 20);
        applyStimulus(1'b1, 2'd2, 1'b0, 1);
        checkOutput("rateChgRx", rx0, 0);
        checkOutput("rateChgTx", tx0, 0);
        waitEvent(0, 100, cnt);
        checkOutput("rxPeriod2a", cnt, 8);
        waitEvent(0, 100, cnt);
        checkOutput("rxPeriod2b", cnt, 8);

        $display("[TB] sync on terminal count");
        applyStimulus(1'b1, 2'd3, 1'b0, 1);
        waitEvent(0, 100, cnt);
        applyStimulus(1'b1, 2'd3, 1'b0, 3);
        applyStimulus(1'b1, 2'd3, 1'b1, 1);
        checkOutput("syncRx", rx0, 0);
        waitEvent(0, 100, cnt);
        checkOutput("syncFirstRx", cnt, 4);
        rxSeen = 1;
        steps  = 0;
        do begin
            stepCycle();
            steps++;
            rxSeen += int'(rx0);
        end while (!tx0 && steps < 500);
        checkOutput("syncRxToTx", rxSeen, 16);

        $display("[TB] enable drop");
        applyStimulus(1'b0, 2'd3, 1'b0, 5);
        applyStimulus(1'b0, 2'd3, 1'b1, 5);
        checkOutput("enLowRx", rx0, 0);
        checkOutput("enLowTx", tx0, 0);
        checkOutput("enLowBc", bc0, 0);
        enable = 1'b1;
        waitEvent(1, 200, cnt);
        checkOutput("reEnableTx", cnt, 64);

        $display("[TB] fractional span at 8 MHz");
        waitEvent(2, 100, cnt);
        total = 0;
        for (int t = 0; t < 16; t++) begin
            waitEvent(2, 100, cnt);
            total += cnt;
        end
`ifdef BAUD_FRAC_EN
        checkOutput("fracSpan", total, 69);
`else
        checkOutput("fracSpan", total, 64);
`endif

        $display("[TB] randomized traffic");
        for (int it = 0; it < 80; it++) begin
            int         sel;
            logic [1:0] r;
            sel = int'($urandom_range(0, 9));
            r   = 2'($urandom_range(0, 3));
            if (sel == 0) begin
                resetn = 1'b0;
                repeat ($urandom_range(1, 5)) stepCycle();
                resetn = 1'b1;
                applyStimulus(1'b1, baud_rate, 1'b0, int'($urandom_range(1, 100)));
            end else if (sel == 1) begin
                applyStimulus(1'b0, r, 1'($urandom_range(0, 1)), int'($urandom_range(1, 20)));
            end else if (sel == 2) begin
                applyStimulus(1'b1, baud_rate, 1'b1, int'($urandom_range(1, 150)));
            end else if (sel == 3) begin
                applyStimulus(1'b1, r, 1'b0, int'($urandom_range(1, 150)));
            end else begin
                applyStimulus(1'b1, baud_rate, 1'b0, int'($urandom_range(1, 150)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
